// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment display path (encoder and readback).
// Latency: n/a (constants and types only).
// Backpressure: n/a.
// Contents: active-low gfedcba segment codes, readback FSM state type, defaults.
package seg_pkg;

  // Default parameter values for seg_readback.
  localparam int NUM_DIGITS_DEF    = 4;
  localparam int STABLE_CYCLES_DEF = 16;
  localparam int CNT_W_DEF         = 5;

  // Active-low segment codes, bit order gfedcba (bit0 = a).
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Per-digit capture FSM.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DWELL = 2'd1,
    HELD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg_decode.sv
// Inverse seven-segment decoder: active-low gfedcba pattern -> nibble.
// Latency: combinational.
// Backpressure: none.
// Ports: seg (pattern in), legal (one of the 16 codes or blank), blank (all off), nibble.
module seg_decode
  import seg_pkg::*;
(
  input  logic [6:0] seg,
  output logic       legal,
  output logic       blank,
  output logic [3:0] nibble
);

  always_comb begin
    legal  = 1'b1;
    blank  = 1'b0;
    nibble = 4'h0;
    case (seg)
      SEG_0:     nibble = 4'h0;
      SEG_1:     nibble = 4'h1;
      SEG_2:     nibble = 4'h2;
      SEG_3:     nibble = 4'h3;
      SEG_4:     nibble = 4'h4;
      SEG_5:     nibble = 4'h5;
      SEG_6:     nibble = 4'h6;
      SEG_7:     nibble = 4'h7;
      SEG_8:     nibble = 4'h8;
      SEG_9:     nibble = 4'h9;
      SEG_A:     nibble = 4'hA;
      SEG_B:     nibble = 4'hB;
      SEG_C:     nibble = 4'hC;
      SEG_D:     nibble = 4'hD;
      SEG_E:     nibble = 4'hE;
      SEG_F:     nibble = 4'hF;
      SEG_BLANK: blank  = 1'b1;
      default:   legal  = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg_readback.sv
// Display loopback monitor: rebuilds the hex word shown on a multiplexed active-low display.
// Latency: 1 cycle pin->pair; capture on STABLE_CYCLES-th identical pair; value_valid 1 edge later.
// Backpressure: none; observes only, emits one value_valid pulse per complete frame.
// Ports: clk, rst (sync, active-high), seg_n/an_n (display lines in),
//        value/blank_mask (last complete frame), value_valid, pattern_err (1-cycle pulses).
module seg_readback
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = NUM_DIGITS_DEF,
  parameter int STABLE_CYCLES = STABLE_CYCLES_DEF,
  parameter int CNT_W         = CNT_W_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_n,
  input  logic [NUM_DIGITS-1:0]   an_n,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   blank_mask,
  output logic                    value_valid,
  output logic                    pattern_err
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [CNT_W-1:0] STABLE_C = CNT_W'(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [6:0]                  seg_r, seg_p;
  logic [NUM_DIGITS-1:0]       an_r, an_p;
  state_t                      state, state_nxt;
  logic [CNT_W-1:0]            cnt, cnt_nxt;
  logic [NUM_DIGITS-1:0]       mask, mask_nxt;
  logic [NUM_DIGITS-1:0][3:0]  slot_nib;
  logic [NUM_DIGITS-1:0]       slot_blank;
  logic [NUM_DIGITS-1:0]       an_act;
  logic                        sel_ok, same, judge, frame_done;
  logic [IDX_W-1:0]            sel_idx;
  logic                        dec_legal, dec_blank;
  logic [3:0]                  dec_nib;

  seg_decode u_dec (
    .seg    (seg_r),
    .legal  (dec_legal),
    .blank  (dec_blank),
    .nibble (dec_nib)
  );

  // Exactly one enable low: the active-high vector is non-zero and a power of two.
  assign an_act     = ~an_r;
  assign sel_ok     = (an_act != '0) && ((an_act & (an_act - 1'b1)) == '0);
  assign same       = (seg_r == seg_p) && (an_r == an_p);
  assign frame_done = &mask;

  always_comb begin
    sel_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (an_act[i]) sel_idx = IDX_W'(i);
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    judge     = 1'b0;
    case (state)
      IDLE: begin
        if (sel_ok) begin
          state_nxt = DWELL;
          cnt_nxt   = 1;
        end else begin
          cnt_nxt   = '0;
        end
      end
      DWELL: begin
        if (!sel_ok) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
        end else if (!same) begin
          cnt_nxt   = 1;
        end else begin
          if (cnt != CNT_MAX) cnt_nxt = cnt + 1'b1;
          // Judge only on the edge that lands exactly on the threshold.
          if ((cnt + 1'b1) == STABLE_C) begin
            judge     = 1'b1;
            state_nxt = HELD;
          end
        end
      end
      HELD: begin
        if (!same) begin
          if (sel_ok) begin
            state_nxt = DWELL;
            cnt_nxt   = 1;
          end else begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  // A completed frame clears the mask first, so a capture on the same edge
  // starts the next frame. An illegal pattern abandons the whole frame.
  always_comb begin
    mask_nxt = frame_done ? '0 : mask;
    if (judge) begin
      if (dec_legal) mask_nxt[sel_idx] = 1'b1;
      else           mask_nxt          = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      seg_r       <= '1;
      an_r        <= '1;
      seg_p       <= '1;
      an_p        <= '1;
      state       <= IDLE;
      cnt         <= '0;
      mask        <= '0;
      slot_nib    <= '0;
      slot_blank  <= '0;
      value       <= '0;
      blank_mask  <= '0;
      value_valid <= 1'b0;
      pattern_err <= 1'b0;
    end else begin
      seg_r       <= seg_n;
      an_r        <= an_n;
      seg_p       <= seg_r;
      an_p        <= an_r;
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      mask        <= mask_nxt;
      value_valid <= frame_done;
      pattern_err <= judge && !dec_legal;
      if (judge && dec_legal) begin
        slot_nib[sel_idx]   <= dec_nib;
        slot_blank[sel_idx] <= dec_blank;
      end
      if (frame_done) begin
        value      <= slot_nib;
        blank_mask <= slot_blank;
      end
    end
  end

endmodule

// File: tb/tb_seg_readback.sv
// Directed bench for seg_readback: scans the display lines and checks reconstructed frames.
// Latency: n/a.
// Backpressure: n/a.
module tb_seg_readback;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg_n;
  logic [3:0]  an_n;
  logic [15:0] value;
  logic [3:0]  blank_mask;
  logic        value_valid;
  logic        pattern_err;

  int n_tests = 0;
  int n_fail  = 0;
  int vv_cnt, pe_cnt, both_cnt;
  logic [15:0] last_val;
  logic [3:0]  last_blank;

  seg_readback #(
    .NUM_DIGITS    (4),
    .STABLE_CYCLES (16),
    .CNT_W         (5)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .seg_n       (seg_n),
    .an_n        (an_n),
    .value       (value),
    .blank_mask  (blank_mask),
    .value_valid (value_valid),
    .pattern_err (pattern_err)
  );

  always #5 clk = ~clk;

  // Pulse monitor, sampled on the inactive edge.
  always @(negedge clk) begin
    if (value_valid) begin
      vv_cnt     = vv_cnt + 1;
      last_val   = value;
      last_blank = blank_mask;
    end
    if (pattern_err) pe_cnt = pe_cnt + 1;
    if (value_valid && pattern_err) both_cnt = both_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests = n_tests + 1;
    if (got !== exp) begin
      n_fail = n_fail + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clr();
    vv_cnt     = 0;
    pe_cnt     = 0;
    last_val   = 16'h0;
    last_blank = 4'h0;
  endtask

  task automatic drive(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_n  = an;
    seg_n = seg;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle();
    drive(4'b1111, 7'h7F, 4);
  endtask

  task automatic scan4(input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input int n);
    drive(4'b1110, s0, n);
    drive(4'b1101, s1, n);
    drive(4'b1011, s2, n);
    drive(4'b0111, s3, n);
    idle();
  endtask

  initial begin
    both_cnt = 0;
    clr();
    rst   = 1'b1;
    an_n  = 4'b1111;
    seg_n = 7'h7F;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_blank", 32'(blank_mask), 32'h0);
    chk("rst_vv", 32'(value_valid), 32'h0);
    chk("rst_perr", 32'(pattern_err), 32'h0);
    rst = 1'b0;

    // Dwells too short for capture.
    clr();
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 10);
    chk("short_vv", 32'(vv_cnt), 32'd0);
    chk("short_value", 32'(value), 32'h0);

    // Clean frame 1/2/3/4.
    clr();
    scan4(7'h79, 7'h24, 7'h30, 7'h19, 20);
    chk("f1_vv", 32'(vv_cnt), 32'd1);
    chk("f1_value", 32'(last_val), 32'h4321);
    chk("f1_blank", 32'(last_blank), 32'h0);
    chk("f1_perr", 32'(pe_cnt), 32'd0);

    // Illegal 7E on digit2 abandons the frame; a later digit2 alone cannot complete it.
    clr();
    drive(4'b1110, 7'h79, 20);
    drive(4'b1101, 7'h12, 20);
    drive(4'b1011, 7'h7E, 20);
    drive(4'b0111, 7'h40, 20);
    drive(4'b1011, 7'h46, 20);
    idle();
    chk("ill_perr", 32'(pe_cnt), 32'd1);
    chk("ill_vv", 32'(vv_cnt), 32'd0);
    chk("ill_value_hold", 32'(value), 32'h4321);
    clr();
    drive(4'b1110, 7'h79, 20);
    drive(4'b1101, 7'h12, 20);
    idle();
    chk("ill_next_vv", 32'(vv_cnt), 32'd1);
    chk("ill_next_value", 32'(last_val), 32'h0C51);

    // Invalid selections never capture.
    clr();
    drive(4'b1100, 7'h79, 30);
    drive(4'b1111, 7'h79, 30);
    chk("nosel_vv", 32'(vv_cnt), 32'd0);
    chk("nosel_perr", 32'(pe_cnt), 32'd0);

    // Interrupted dwell on digit0 restarts its counter.
    clr();
    drive(4'b1110, 7'h02, 10);
    drive(4'b1111, 7'h02, 5);
    drive(4'b1110, 7'h02, 10);
    drive(4'b1101, 7'h78, 20);
    drive(4'b1011, 7'h00, 20);
    drive(4'b0111, 7'h10, 20);
    idle();
    chk("restart_vv", 32'(vv_cnt), 32'd0);
    clr();
    drive(4'b1110, 7'h02, 20);
    idle();
    chk("restart_done_vv", 32'(vv_cnt), 32'd1);
    chk("restart_value", 32'(last_val), 32'h9876);

    // Letters and a blank digit.
    clr();
    scan4(7'h0E, 7'h06, 7'h08, 7'h7F, 20);
    chk("blank_vv", 32'(vv_cnt), 32'd1);
    chk("blank_value", 32'(last_val), 32'h0AEF);
    chk("blank_mask", 32'(last_blank), 32'b1000);

    // Reset mid-frame discards digits 0 and 1.
    clr();
    drive(4'b1110, 7'h21, 20);
    drive(4'b1101, 7'h46, 20);
    an_n  = 4'b1111;
    rst   = 1'b1;
    @(posedge clk);
    #1;
    rst   = 1'b0;
    chk("mid_rst_value", 32'(value), 32'h0);
    chk("mid_rst_blank", 32'(blank_mask), 32'h0);
    drive(4'b1011, 7'h03, 20);
    drive(4'b0111, 7'h08, 20);
    idle();
    chk("post_rst_partial_vv", 32'(vv_cnt), 32'd0);
    drive(4'b1110, 7'h21, 20);
    drive(4'b1101, 7'h46, 20);
    idle();
    chk("post_rst_vv", 32'(vv_cnt), 32'd1);
    chk("post_rst_value", 32'(last_val), 32'hABCD);
    chk("post_rst_blank", 32'(last_blank), 32'h0);

    chk("vv_perr_overlap", 32'(both_cnt), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
